// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor with valid/ready handshakes, flush-to-zero.
// Define FP_ADDSUB_SKID_EN to add an output skid entry so in_ready comes straight from a flop.
module fp_addsub_pipe #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [EW+MW:0] in1,
    input  logic [EW+MW:0] in2,
    input  logic           op,
    input  logic [2:0]     round_m,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW+MW:0] out,
    output logic           ov,
    output logic           un,
    output logic           inv,
    output logic           inexact
);
    localparam int W   = 1 + EW + MW;
    localparam int MT  = MW + 4;              // hidden bit, fraction, guard, round, sticky
    localparam int LZW = $clog2(MT + 1);
    localparam int XW  = EW + 2;              // exponent with headroom and a sign bit
    localparam int RW  = W + 4;
    localparam logic [EW-1:0] EMAX   = '1;
    localparam logic [MT-1:0] ONES   = '1;
    localparam logic [2:0]    RM_RNE = 3'd0;
    localparam logic [2:0]    RM_RZ  = 3'd1;
    localparam logic [2:0]    RM_RD  = 3'd2;
    localparam logic [2:0]    RM_RU  = 3'd3;
    localparam logic [2:0]    RM_RNA = 3'd4;
    localparam logic [W-1:0]  QNAN   = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};

    logic adv;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic          sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, zl, zs;
    logic [EW-1:0] ea, eb, e_s, shamt;
    logic [MW-1:0] fa, fb, f_l, f_s;
    logic [MT-1:0] m_s, m_sh;

    logic          v1_q, sub1_q, sign1_q, spec1_q, specinv1_q, zsign1_q;
    logic          sub1_d, sign1_d, spec1_d, specinv1_d, zsign1_d;
    logic [EW-1:0] exp1_q, exp1_d;
    logic [MT-1:0] ml1_q, ms1_q, ml1_d, ms1_d;
    logic [W-1:0]  specw1_q, specw1_d;
    logic [2:0]    rm1_q, rm1_d;

    assign sa = in1[W-1];
    assign sb = in2[W-1] ^ op;
    assign ea = in1[W-2:MW];
    assign eb = in2[W-2:MW];
    assign fa = in1[MW-1:0];
    assign fb = in2[MW-1:0];

    always_comb begin
        a_nan  = (&ea) & (|fa);
        b_nan  = (&eb) & (|fb);
        a_inf  = (&ea) & ~(|fa);
        b_inf  = (&eb) & ~(|fb);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        rm1_d  = (round_m > RM_RNA) ? RM_RNE : round_m;
        swap   = (b_zero ? '0 : in2[W-2:0]) > (a_zero ? '0 : in1[W-2:0]);
        sign1_d = swap ? sb : sa;
        exp1_d  = swap ? eb : ea;
        e_s     = swap ? ea : eb;
        f_l     = swap ? fb : fa;
        f_s     = swap ? fa : fb;
        zl      = swap ? b_zero : a_zero;
        zs      = swap ? a_zero : b_zero;
        sub1_d  = sa ^ sb;
        ml1_d   = zl ? '0 : {1'b1, f_l, 3'b000};
        m_s     = zs ? '0 : {1'b1, f_s, 3'b000};
        shamt   = exp1_d - e_s;
        m_sh    = m_s >> shamt;
        ms1_d   = {m_sh[MT-1:1], m_sh[0] | (|(m_s & ~(ONES << shamt)))};
        zsign1_d = (a_zero && b_zero && (sa == sb)) ? sa : (rm1_d == RM_RD);
        spec1_d    = 1'b0;
        specw1_d   = '0;
        specinv1_d = 1'b0;
        if (a_nan || b_nan) begin
            spec1_d    = 1'b1;
            specw1_d   = QNAN;
            specinv1_d = (a_nan & ~fa[MW-1]) | (b_nan & ~fb[MW-1]);
        end else if (a_inf && b_inf && (sa != sb)) begin
            spec1_d    = 1'b1;
            specw1_d   = QNAN;
            specinv1_d = 1'b1;
        end else if (a_inf || b_inf) begin
            spec1_d  = 1'b1;
            specw1_d = {a_inf ? sa : sb, EMAX, {MW{1'b0}}};
        end
    end

    // ---------------- S2: add/subtract and normalize ----------------
    logic [MT:0]    sum;
    logic [LZW-1:0] lz;
    logic           v2_q, sign2_q, spec2_q, specinv2_q, zsign2_q;
    logic [XW-1:0]  exp2_q, exp2_d;
    logic [MT-1:0]  norm2_q, norm2_d;
    logic [W-1:0]   specw2_q;
    logic [2:0]     rm2_q;

    always_comb begin
        sum = sub1_q ? ({1'b0, ml1_q} - {1'b0, ms1_q}) : ({1'b0, ml1_q} + {1'b0, ms1_q});
        lz  = '0;
        for (int i = 0; i < MT; i++) begin
            if (sum[i]) lz = LZW'(MT - 1 - i);
        end
        if (sum[MT]) begin
            norm2_d = {sum[MT:2], sum[1] | sum[0]};
            exp2_d  = {2'b00, exp1_q} + XW'(1);
        end else begin
            norm2_d = sum[MT-1:0] << lz;
            exp2_d  = {2'b00, exp1_q} - XW'(lz);
        end
    end

    // ---------------- S3: round and select exceptions ----------------
    logic          grs, inc, ov3, un3, inv3, ix3;
    logic [MW+1:0] rnd;
    logic [XW-1:0] exp3;
    logic [W-1:0]  out3, maxf, inf_w;
    logic [RW-1:0] res3, res_q;

    always_comb begin
        grs = |norm2_q[2:0];
        case (rm2_q)
            RM_RZ:   inc = 1'b0;
            RM_RD:   inc = sign2_q & grs;
            RM_RU:   inc = ~sign2_q & grs;
            RM_RNA:  inc = norm2_q[2];
            default: inc = norm2_q[2] & (norm2_q[3] | norm2_q[1] | norm2_q[0]);
        endcase
        rnd   = {1'b0, norm2_q[MT-1:3]} + (MW+2)'(inc);
        exp3  = exp2_q + XW'(rnd[MW+1]);
        maxf  = {sign2_q, EMAX - EW'(1), {MW{1'b1}}};
        inf_w = {sign2_q, EMAX, {MW{1'b0}}};
        ov3 = 1'b0;
        un3 = 1'b0;
        inv3 = 1'b0;
        ix3 = 1'b0;
        out3 = {sign2_q, exp3[EW-1:0], rnd[MW-1:0]};
        if (spec2_q) begin
            out3 = specw2_q;
            inv3 = specinv2_q;
        end else if (!(rnd[MW+1] | rnd[MW])) begin
            out3 = {zsign2_q, {(W-1){1'b0}}};
        end else if (!exp3[XW-1] && (exp3 >= {2'b00, EMAX})) begin
            ov3 = 1'b1;
            ix3 = 1'b1;
            case (rm2_q)
                RM_RZ:   out3 = maxf;
                RM_RD:   out3 = sign2_q ? inf_w : maxf;
                RM_RU:   out3 = sign2_q ? maxf : inf_w;
                default: out3 = inf_w;
            endcase
        end else if (exp3[XW-1] || (exp3 == '0)) begin
            out3 = {sign2_q, {(W-1){1'b0}}};
            un3  = 1'b1;
            ix3  = 1'b1;
        end else begin
            ix3 = grs;
        end
        res3 = {ov3, un3, inv3, ix3, out3};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;  sub1_q <= 1'b0;  sign1_q <= 1'b0;  spec1_q <= 1'b0;
            specinv1_q <= 1'b0;  zsign1_q <= 1'b0;  exp1_q <= '0;  ml1_q <= '0;
            ms1_q <= '0;  specw1_q <= '0;  rm1_q <= '0;
            v2_q <= 1'b0;  sign2_q <= 1'b0;  spec2_q <= 1'b0;  specinv2_q <= 1'b0;
            zsign2_q <= 1'b0;  exp2_q <= '0;  norm2_q <= '0;  specw2_q <= '0;  rm2_q <= '0;
        end else if (adv) begin
            v1_q <= in_valid;  sub1_q <= sub1_d;  sign1_q <= sign1_d;  spec1_q <= spec1_d;
            specinv1_q <= specinv1_d;  zsign1_q <= zsign1_d;  exp1_q <= exp1_d;
            ml1_q <= ml1_d;  ms1_q <= ms1_d;  specw1_q <= specw1_d;  rm1_q <= rm1_d;
            v2_q <= v1_q;  sign2_q <= sign1_q;  spec2_q <= spec1_q;  specinv2_q <= specinv1_q;
            zsign2_q <= zsign1_q;  exp2_q <= exp2_d;  norm2_q <= norm2_d;
            specw2_q <= specw1_q;  rm2_q <= rm1_q;
        end
    end

    logic out_valid_q;

`ifdef FP_ADDSUB_SKID_EN
    // Pipeline runs while the skid entry is free; a result produced under stall parks there.
    logic          skid_v_q;
    logic [RW-1:0] skid_q;

    assign adv = ~skid_v_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            skid_v_q    <= 1'b0;
            skid_q      <= '0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_v_q) begin
                res_q       <= skid_q;
                out_valid_q <= 1'b1;
                skid_v_q    <= 1'b0;
            end else begin
                res_q       <= res3;
                out_valid_q <= v2_q;
            end
        end else if (v2_q && !skid_v_q) begin
            skid_q   <= res3;
            skid_v_q <= 1'b1;
        end
    end
`else
    assign adv = ~out_valid_q | out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (adv) begin
            out_valid_q <= v2_q;
            res_q       <= res3;
        end
    end
`endif

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign {ov, un, inv, inexact, out} = res_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe (binary32 defaults): single ops, stalls, throughput, reset.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        op = 1'b0;
    logic [2:0]  round_m = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, ov, un, inv, inexact;
    logic [31:0] out;

    fp_addsub_pipe dut (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .op(op), .round_m(round_m),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .ov(ov), .un(un), .inv(inv), .inexact(inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [3:0]  flg;   // {ov, un, inv, inexact}
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addv(input logic [31:0] a, input logic [31:0] b, input logic o,
                        input logic [2:0] rm, input logic [31:0] res, input logic [3:0] flg);
        vec_t v;
        v.a = a; v.b = b; v.op = o; v.rm = rm; v.res = res; v.flg = flg;
        vq.push_back(v);
    endtask

    task automatic apply(input int idx);
        vec_t v;
        int lat;
        v = vq[idx];
        @(negedge clk);
        in1 = v.a; in2 = v.b; op = v.op; round_m = v.rm;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 chk($sformatf("v%0d_in_ready", idx), {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), lat, 32'd3);
        chk($sformatf("v%0d_out", idx), out, v.res);
        chk($sformatf("v%0d_flags", idx), {28'b0, ov, un, inv, inexact}, {28'b0, v.flg});
        $display("vec %0d: %h %s %h rm=%0d -> %h flags=%b%b%b%b", idx, v.a, v.op ? "-" : "+",
                 v.b, v.rm, out, ov, un, inv, inexact);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int tx, rx, cyc, stale;
        logic acc, held_v;
        logic [31:0] held;

        addv(32'h3F800000, 32'h40000000, 1'b0, 3'd0, 32'h40400000, 4'b0000);
        addv(32'h7F800000, 32'h7F800000, 1'b1, 3'd0, 32'h7FC00000, 4'b0010);
        addv(32'h7F800001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 4'b0010);
        addv(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, 32'h7F7FFFFF, 4'b1001);
        addv(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 32'h7F800000, 4'b1001);
        addv(32'h3F800000, 32'h33800000, 1'b0, 3'd0, 32'h3F800000, 4'b0001);
        addv(32'h3F800000, 32'h33800000, 1'b0, 3'd4, 32'h3F800001, 4'b0001);
        addv(32'h3F800000, 32'h33800000, 1'b0, 3'd3, 32'h3F800001, 4'b0001);
        addv(32'h3F800000, 32'h3F800000, 1'b1, 3'd2, 32'h80000000, 4'b0000);
        addv(32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 32'h00000000, 4'b0000);
        addv(32'h3F800000, 32'h33800000, 1'b0, 3'd5, 32'h3F800000, 4'b0001);
        addv(32'h7FC00000, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 4'b0000);
        addv(32'hFF800000, 32'h3F800000, 1'b0, 3'd0, 32'hFF800000, 4'b0000);
        addv(32'h3F800000, 32'h7F800000, 1'b1, 3'd0, 32'hFF800000, 4'b0000);
        addv(32'h80000000, 32'h80000000, 1'b0, 3'd0, 32'h80000000, 4'b0000);
        addv(32'h00000000, 32'h80000000, 1'b0, 3'd0, 32'h00000000, 4'b0000);
        addv(32'h00000000, 32'h80000000, 1'b0, 3'd2, 32'h80000000, 4'b0000);
        addv(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd2, 32'h7F7FFFFF, 4'b1001);
        addv(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd3, 32'h7F800000, 4'b1001);
        addv(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd3, 32'hFF7FFFFF, 4'b1001);
        addv(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd2, 32'hFF800000, 4'b1001);
        addv(32'h00C00000, 32'h00800000, 1'b1, 3'd0, 32'h00000000, 4'b0101);
        addv(32'h00000001, 32'h3F800000, 1'b0, 3'd0, 32'h3F800000, 4'b0000);
        addv(32'h3F800001, 32'h33800000, 1'b0, 3'd0, 32'h3F800002, 4'b0001);
        addv(32'h3FFFFFFF, 32'h33800000, 1'b0, 3'd0, 32'h40000000, 4'b0001);
        addv(32'hBF800000, 32'hB3800000, 1'b0, 3'd2, 32'hBF800001, 4'b0001);
        addv(32'hBF800000, 32'hB3800000, 1'b0, 3'd1, 32'hBF800000, 4'b0001);
        addv(32'h3F800000, 32'h33000000, 1'b0, 3'd0, 32'h3F800000, 4'b0001);
        addv(32'h3F800000, 32'h33000000, 1'b0, 3'd3, 32'h3F800001, 4'b0001);
        addv(32'h3F800000, 32'h00800000, 1'b0, 3'd3, 32'h3F800001, 4'b0001);
        addv(32'h3FC00000, 32'h3F800000, 1'b1, 3'd0, 32'h3F000000, 4'b0000);
        addv(32'h3F800000, 32'h33000000, 1'b1, 3'd0, 32'h3F800000, 4'b0001);
        addv(32'h3F800000, 32'h33000000, 1'b1, 3'd1, 32'h3F7FFFFF, 4'b0001);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_flags", {28'b0, ov, un, inv, inexact}, 32'd0);
        rst = 1'b1;
        #1 chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Isolated operations
        for (int i = 0; i < vq.size(); i++) apply(i);

        // Back-to-back with out_ready toggling every cycle
        tx = 0; rx = 0; cyc = 0; held_v = 1'b0; held = '0;
        while (rx < 8 && cyc < 200) begin
            @(negedge clk);
            out_ready = (cyc % 2 == 1);
            if (held_v) begin
                chk("b2b_stall_valid", {31'b0, out_valid}, 32'd1);
                chk("b2b_stall_hold", out, held);
            end
            in_valid = (tx < 8);
            if (tx < 8) begin
                in1 = vq[tx].a; in2 = vq[tx].b; op = vq[tx].op; round_m = vq[tx].rm;
            end
            #1;
            acc = in_valid && in_ready;
            held_v = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    chk($sformatf("b2b_out%0d", rx), out, vq[rx].res);
                    $display("b2b result %0d: %h", rx, out);
                    rx++;
                end else begin
                    held_v = 1'b1;
                    held = out;
                end
            end
            @(posedge clk);
            if (acc) tx++;
            cyc++;
        end
        chk("b2b_issued", tx, 32'd8);
        chk("b2b_received", rx, 32'd8);
        in_valid = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("b2b_no_duplicate", stale, 32'd0);

        // Full throughput: four ops on consecutive cycles, results on consecutive cycles
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (k < 4);
            if (k < 4) begin
                in1 = vq[5+k].a; in2 = vq[5+k].b; op = vq[5+k].op; round_m = vq[5+k].rm;
            end
            #1;
            if (k < 4) chk($sformatf("tp_in_ready%0d", k), {31'b0, in_ready}, 32'd1);
            if (k >= 3 && k <= 6) begin
                chk($sformatf("tp_valid%0d", k), {31'b0, out_valid}, 32'd1);
                chk($sformatf("tp_out%0d", k), out, vq[5+k-3].res);
                $display("throughput result %0d: %h", k - 3, out);
            end else begin
                chk($sformatf("tp_idle%0d", k), {31'b0, out_valid}, 32'd0);
            end
        end
        in_valid = 1'b0;

        // Reset with two operations in flight
        @(negedge clk);
        in1 = vq[0].a; in2 = vq[0].b; op = vq[0].op; round_m = vq[0].rm;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in1 = vq[5].a; in2 = vq[5].b; op = vq[5].op; round_m = vq[5].rm;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_pre_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out", out, 32'd0);
        chk("mid_rst_flags", {28'b0, ov, un, inv, inexact}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("mid_rst_no_stale", stale, 32'd0);
        $display("reset mid-flight: stale results %0d", stale);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
